// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-port data memory behind a small request/response FSM
//   (IDLE -> WAIT -> RESP). A request is captured in IDLE. WAIT_STATES wait
//   cycles follow. Then a one-cycle ready strobe is returned with load data or
//   a misalignment flag.
//
// Ports
//   clk        : clock, rising edge
//   rstN       : asynchronous active-low reset (memory contents are kept)
//   ramEn      : request valid, held until ready
//   MemRW      : 1 = store, 0 = load
//   addr       : byte address (wraps modulo DEPTH_WORDS*4)
//   wdata      : right-aligned store data
//   size       : 00 byte, 01 half, 1x word
//   ldUnsigned : 1 = zero-extend loads, 0 = sign-extend
//   ramOut     : extended load data, held between loads
//   ready      : one-cycle response strobe
//   err        : misaligned access flag, qualified by ready
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        ramEn,
  input  logic        MemRW,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        ldUnsigned,
  output logic [31:0] ramOut,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Last counter value spent in WAIT. This value is unused when WAIT_STATES is 0.
  localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [3:0]       cnt_r;
  logic [AW+1:0]    addr_r;
  logic [31:0]      wdata_r;
  logic [1:0]       size_r;
  logic             rw_r, uns_r;
  logic [31:0]      ramout_r;
  logic             ready_r, err_r;
  logic [31:0]      mem_r [DEPTH_WORDS];

  logic [AW+1:0]    cur_addr_s;
  logic [31:0]      cur_wdata_s;
  logic [1:0]       cur_size_s;
  logic             cur_rw_s, cur_uns_s;
  logic             accept_s, enter_resp_s, mis_s, we_s;
  logic [AW-1:0]    idx_s;
  logic [3:0]       mask_s;
  logic [31:0]      wal_s, rd_word_s;
  logic             unused_s;

  // Half needs an even address; word needs a 4-byte aligned address.
  function automatic logic misaligned_f(input logic [1:0] sz, input logic [1:0] a);
    logic m;
    case (sz)
      2'b00:   m = 1'b0;
      2'b01:   m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction

  // Byte lanes touched by an aligned store.
  function automatic logic [3:0] lane_mask_f(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replicate the right-aligned data so that every lane carries it. The lane mask then picks the lanes to write.
  function automatic logic [31:0] store_align_f(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Pull the addressed byte/half down to bit 0 and extend it.
  function automatic logic [31:0] load_extract_f(input logic [1:0] sz, input logic [1:0] a,
                                                 input logic [31:0] word, input logic uns);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {a, 3'b000};
    case (sz)
      2'b00:   r = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   r = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  // Request view: live inputs while IDLE (zero-wait case commits on the accept edge), latched copy afterwards.
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_addr_s  = addr[AW+1:0];
      cur_wdata_s = wdata;
      cur_size_s  = size;
      cur_rw_s    = MemRW;
      cur_uns_s   = ldUnsigned;
    end else begin
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
      cur_size_s  = size_r;
      cur_rw_s    = rw_r;
      cur_uns_s   = uns_r;
    end
  end

  // Next-state logic; enter_resp_s marks the edge where the access takes effect.
  always_comb begin
    state_nxt_s  = state_r;
    enter_resp_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ramEn) begin
          if (WAIT_STATES == 0) begin
            state_nxt_s  = ST_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s  = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign accept_s  = (state_r == ST_IDLE) && ramEn;
  assign mis_s     = misaligned_f(cur_size_s, cur_addr_s[1:0]);
  assign idx_s     = cur_addr_s[AW+1:2];
  assign mask_s    = lane_mask_f(cur_size_s, cur_addr_s[1:0]);
  assign wal_s     = store_align_f(cur_size_s, cur_wdata_s);
  assign rd_word_s = mem_r[idx_s];
  // rstN gating keeps a clock edge during reset from committing anything.
  assign we_s      = enter_resp_s && cur_rw_s && !mis_s && rstN;
  // Address bits above the memory size are ignored so that accesses wrap around.
  assign unused_s  = ^addr[31:AW+2];

  // Control state, request latch and registered response outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      addr_r   <= '0;
      wdata_r  <= 32'h0000_0000;
      size_r   <= 2'b00;
      rw_r     <= 1'b0;
      uns_r    <= 1'b0;
      ramout_r <= 32'h0000_0000;
      ready_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        cnt_r   <= 4'd0;
        addr_r  <= addr[AW+1:0];
        wdata_r <= wdata;
        size_r  <= size;
        rw_r    <= MemRW;
        uns_r   <= ldUnsigned;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r + 4'd1;
      end
      ready_r <= enter_resp_s;
      err_r   <= enter_resp_s && mis_s;
      if (enter_resp_s) begin
        if (mis_s) begin
          ramout_r <= 32'h0000_0000;
        end else if (!cur_rw_s) begin
          ramout_r <= load_extract_f(cur_size_s, cur_addr_s[1:0], rd_word_s, cur_uns_s);
        end
      end
    end
  end

  // Storage array; deliberately not reset so contents survive rstN.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_s && mask_s[i]) begin
        mem_r[idx_s][8*i +: 8] <= wal_s[8*i +: 8];
      end
    end
  end

  assign ramOut = ramout_r;
  assign ready  = ready_r;
  assign err    = err_r;

endmodule
